// File: rtl/ring_seq_decoder.sv
// ring_seq_decoder: decodes a ring (one-hot) or Johnson counter state bus into a
// binary position, tracks the step sequence, locks onto a valid +1 sequence and
// flags/counts sequence errors once locked.
module ring_seq_decoder #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned LOCK_CNT = 2,
  localparam int unsigned PW      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic [PW-1:0]    pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [7:0]       err_cnt
);

  localparam int unsigned N  = (MODE == 0) ? WIDTH : 2 * WIDTH;
  localparam int unsigned CW = 4;

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_match;
  logic [PW-1:0]   r_prev_pos;
  logic            r_prev_valid;
  logic [PW-1:0]   r_pos;
  logic            r_pos_valid;
  logic            r_locked;
  logic            r_err;
  logic            r_wrap;
  logic [7:0]      r_err_cnt;

  logic            w_legal;
  logic [PW-1:0]   w_pos;
  logic [PW-1:0]   w_nxt;
  logic            w_at_top;
  logic            w_adv;
  logic            w_stall;
  logic [CW-1:0]   w_match_nxt;

  // Code check and position decode of the sampled state bus
  always_comb begin
    logic [WIDTH-1:0] v_ones;
    logic [WIDTH-1:0] v_zeros;
    w_legal = 1'b0;
    w_pos   = '0;
    v_ones  = '0;
    v_zeros = '1;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (q_in == (WIDTH'(1) << i)) begin
          w_legal = 1'b1;
          w_pos   = PW'(i);
        end
      end
    end else begin
      // Filling half: low k bits set, k = 0..WIDTH
      for (int unsigned k = 0; k <= WIDTH; k++) begin
        if (q_in == v_ones) begin
          w_legal = 1'b1;
          w_pos   = PW'(k);
        end
        v_ones = {v_ones[WIDTH-2:0], 1'b1};
      end
      // Draining half: low j bits clear, rest set, j = 1..WIDTH-1
      for (int unsigned j = 1; j < WIDTH; j++) begin
        v_zeros = {v_zeros[WIDTH-2:0], 1'b0};
        if (q_in == v_zeros) begin
          w_legal = 1'b1;
          w_pos   = PW'(WIDTH + j);
        end
      end
    end
  end

  // Step classification relative to the previous legal sample
  always_comb begin
    w_at_top    = (r_prev_pos == PW'(N - 1));
    w_nxt       = w_at_top ? '0 : r_prev_pos + PW'(1);
    w_adv       = w_legal && r_prev_valid && (w_pos == w_nxt);
    w_stall     = w_legal && r_prev_valid && (w_pos == r_prev_pos);
    w_match_nxt = r_match + CW'(1);
  end

  // Lock tracker FSM with registered decode, pulse and error-count outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_HUNT;
      r_match      <= '0;
      r_prev_pos   <= '0;
      r_prev_valid <= 1'b0;
      r_pos        <= '0;
      r_pos_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      if (en) begin
        r_pos_valid  <= w_legal;
        r_prev_valid <= w_legal;
        if (w_legal) begin
          r_pos      <= w_pos;
          r_prev_pos <= w_pos;
        end
        case (r_state)
          S_HUNT: begin
            if (w_adv) begin
              if (w_match_nxt == CW'(LOCK_CNT)) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
                r_match  <= '0;
              end else begin
                r_match <= w_match_nxt;
              end
            end else if (!w_stall) begin
              r_match <= '0;
            end
          end
          S_LOCKED: begin
            if (w_adv || w_stall) begin
              r_wrap <= w_adv && w_at_top;
            end else begin
              // Illegal code or jump breaks lock; this sample also seeds the new hunt
              r_err    <= 1'b1;
              r_locked <= 1'b0;
              r_match  <= '0;
              r_state  <= S_HUNT;
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
            end
          end
          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
            r_match  <= '0;
          end
        endcase
      end
    end
  end

  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;
  assign locked    = r_locked;
  assign err       = r_err;
  assign wrap      = r_wrap;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ring_seq_decoder.sv
// Bench for ring_seq_decoder: one ring and one Johnson instance, a behavioural
// reference model feeding a scoreboard queue, plus directed checks.
module tb_ring_seq_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned LC = 2;

  logic       clk;
  logic       clr_n;
  logic       en0, en1;
  logic [3:0] q0, q1;
  logic [2:0] pos0, pos1;
  logic       pv0, pv1, lk0, lk1, er0, er1, wr0, wr1;
  logic [7:0] ec0, ec1;

  ring_seq_decoder #(.WIDTH(W), .MODE(0), .LOCK_CNT(LC)) u_ring (
    .clk(clk), .clr_n(clr_n), .en(en0), .q_in(q0), .pos(pos0), .pos_valid(pv0),
    .locked(lk0), .err(er0), .wrap(wr0), .err_cnt(ec0)
  );

  ring_seq_decoder #(.WIDTH(W), .MODE(1), .LOCK_CNT(LC)) u_john (
    .clk(clk), .clr_n(clr_n), .en(en1), .q_in(q1), .pos(pos1), .pos_valid(pv1),
    .locked(lk1), .err(er1), .wrap(wr1), .err_cnt(ec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int pos, pv, lk, er, wr, ec;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, one slot per instance (0 = ring, 1 = Johnson)
  int m_pos[2], m_pv[2], m_lk[2], m_er[2], m_wr[2], m_ec[2];
  int m_match[2], m_ppos[2], m_pval[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? W : 2 * W;
  endfunction

  // Code word expected at position p for each counter type
  function automatic logic [3:0] code_of(input int d, input int p);
    if (d == 0) return 4'(1 << p);
    if (p <= W) return 4'((1 << p) - 1);
    return 4'(~((1 << (p - W)) - 1));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_pv[d] = 0; m_lk[d] = 0; m_er[d] = 0; m_wr[d] = 0; m_ec[d] = 0;
      m_match[d] = 0; m_ppos[d] = 0; m_pval[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic e, input logic [3:0] q);
    int legal, dp, nn, adv, stall;
    m_er[d] = 0;
    m_wr[d] = 0;
    if (!e) return;
    nn = n_of(d);
    legal = 0; dp = 0;
    for (int p = 0; p < nn; p++) if (q == code_of(d, p)) begin legal = 1; dp = p; end
    adv   = legal && m_pval[d] && (dp == (m_ppos[d] + 1) % nn);
    stall = legal && m_pval[d] && (dp == m_ppos[d]);
    if (!m_lk[d]) begin
      if (adv) begin
        m_match[d]++;
        if (m_match[d] >= LC) begin m_lk[d] = 1; m_match[d] = 0; end
      end else if (!stall) m_match[d] = 0;
    end else begin
      if (adv || stall) begin
        if (adv && m_ppos[d] == nn - 1) m_wr[d] = 1;
      end else begin
        m_er[d] = 1;
        if (m_ec[d] < 255) m_ec[d]++;
        m_lk[d] = 0;
        m_match[d] = 0;
      end
    end
    m_pval[d] = legal;
    m_pv[d]   = legal;
    if (legal) begin m_ppos[d] = dp; m_pos[d] = dp; end
  endtask

  // Drive one cycle on instance d, predict, then compare after the edge
  task automatic cyc(input int d, input logic e, input logic [3:0] q);
    exp_t ex, got;
    if (d == 0) begin en0 = e; q0 = q; en1 = 1'b0; end
    else        begin en1 = e; q1 = q; en0 = 1'b0; end
    model_step(d, e, q);
    ex.d = d; ex.pos = m_pos[d]; ex.pv = m_pv[d]; ex.lk = m_lk[d];
    ex.er = m_er[d]; ex.wr = m_wr[d]; ex.ec = m_ec[d];
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (got.d == 0) begin
      chk("r_pos", int'(pos0), got.pos); chk("r_pv", int'(pv0), got.pv);
      chk("r_lk", int'(lk0), got.lk);    chk("r_err", int'(er0), got.er);
      chk("r_wrap", int'(wr0), got.wr);  chk("r_ecnt", int'(ec0), got.ec);
    end else begin
      chk("j_pos", int'(pos1), got.pos); chk("j_pv", int'(pv1), got.pv);
      chk("j_lk", int'(lk1), got.lk);    chk("j_err", int'(er1), got.er);
      chk("j_wrap", int'(wr1), got.wr);  chk("j_ecnt", int'(ec1), got.ec);
    end
  endtask

  int wraps;

  initial begin
    logic [3:0] ring_seq [5];
    ring_seq[0] = 4'b0001; ring_seq[1] = 4'b0010; ring_seq[2] = 4'b0100;
    ring_seq[3] = 4'b1000; ring_seq[4] = 4'b0001;

    clr_n = 1'b0; en0 = 1'b0; en1 = 1'b0; q0 = '0; q1 = '0;
    model_reset();
    #12;
    chk("rst_pos", int'(pos0), 0); chk("rst_pv", int'(pv0), 0);
    chk("rst_lk", int'(lk0), 0);   chk("rst_ecnt", int'(ec1), 0);
    clr_n = 1'b1;

    // Ring lock and wrap
    wraps = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b1, ring_seq[i]);
      chk("t1_pos", int'(pos0), (i == 4) ? 0 : i);
      if (i == 2) chk("t1_lock3", int'(lk0), 1);
      if (i == 1) chk("t1_nolock2", int'(lk0), 0);
      wraps += int'(wr0);
      chk("t1_noerr", int'(er0), 0);
    end
    chk("t1_wraps", wraps, 1);

    // Illegal code while locked, then re-lock
    cyc(0, 1'b1, 4'b0010);
    cyc(0, 1'b1, 4'b0100);
    cyc(0, 1'b1, 4'b1000);
    cyc(0, 1'b1, 4'b0110);
    chk("t2_err", int'(er0), 1);  chk("t2_ecnt", int'(ec0), 1);
    chk("t2_lk", int'(lk0), 0);   chk("t2_pv", int'(pv0), 0);
    chk("t2_pos", int'(pos0), 3);
    cyc(0, 1'b1, 4'b0001);
    cyc(0, 1'b1, 4'b0010);
    cyc(0, 1'b1, 4'b0100);
    chk("t2_relock", int'(lk0), 1);

    // Johnson walk through all eight states and back to zero, then illegal
    wraps = 0;
    for (int p = 0; p <= 8; p++) begin
      cyc(1, 1'b1, code_of(1, p % 8));
      chk("t3_pos", int'(pos1), p % 8);
      if (p == 2) chk("t3_lock3", int'(lk1), 1);
      wraps += int'(wr1);
    end
    chk("t3_wraps", wraps, 1);
    cyc(1, 1'b1, 4'b0101);
    chk("t3_err", int'(er1), 1); chk("t3_ecnt", int'(ec1), 1);

    // Stall and jump on the ring, with idle cycles in between
    cyc(0, 1'b1, 4'b1000);
    cyc(0, 1'b1, 4'b0001);
    cyc(0, 1'b1, 4'b0010);
    chk("t4_lock", int'(lk0), 1);
    cyc(0, 1'b1, 4'b0010);
    cyc(0, 1'b0, 4'b0110);
    cyc(0, 1'b0, 4'b1000);
    cyc(0, 1'b1, 4'b0010);
    cyc(0, 1'b1, 4'b0010);
    chk("t4_stall_lk", int'(lk0), 1); chk("t4_stall_err", int'(er0), 0);
    cyc(0, 1'b1, 4'b1000);
    chk("t4_jump_err", int'(er0), 1); chk("t4_jump_lk", int'(lk0), 0);
    cyc(0, 1'b0, 4'b0000);
    chk("t4_err_1cyc", int'(er0), 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1'b1, 4'b0001);
      cyc(0, 1'b1, 4'b0010);
      cyc(0, 1'b1, 4'b0100);
      cyc(0, 1'b1, 4'b0110);
    end
    chk("t5_sat", int'(ec0), 255);
    chk("t5_err_pulse", int'(er0), 1);

    // Asynchronous reset between clock edges
    cyc(0, 1'b1, 4'b0001);
    cyc(0, 1'b1, 4'b0010);
    cyc(0, 1'b1, 4'b0100);
    chk("t6_pre_lk", int'(lk0), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_pos", int'(pos0), 0); chk("t6_pv", int'(pv0), 0);
    chk("t6_lk", int'(lk0), 0);   chk("t6_ecnt", int'(ec0), 0);
    chk("t6_j_ecnt", int'(ec1), 0); chk("t6_j_pos", int'(pos1), 0);
    model_reset();
    #1 clr_n = 1'b1;
    cyc(0, 1'b1, 4'b0001);
    cyc(0, 1'b1, 4'b0010);
    chk("t6_one_adv", int'(lk0), 0);
    cyc(0, 1'b1, 4'b0100);
    chk("t6_two_adv", int'(lk0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
